alu_pipe: RTL

- Parametrised, two-stage pipelined successor to the combinational TP1 ALU.
- Keeps the same operation set and opcodes and adds carry, negative and illegal-opcode flags plus a sticky overflow flag.
- Wraps the datapath in valid/ready handshakes on both sides, with full backpressure, so the block can sit between a command source (UART/interface FSM) and a result consumer.
- Sustains one operation per cycle when not stalled.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag layout for the pipelined ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // Packed flags vector layout: {illegal, negative, carry, zero, overflow}
    localparam int FLAG_OVF   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ILL   = 4;
    localparam int NB_FLAGS   = 5;

    typedef logic [NB_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus the packed flags vector.
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] result,
    output flags_t             flags
);

    localparam int                 NB_SHAMT    = $clog2(NB_DATA);
    localparam int                 MSB         = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA[NB_DATA-1:0];

    logic [NB_DATA:0] sum;
    logic [NB_DATA:0] diff;
    logic             shift_oor;

    // Decode the opcode and compute result and flags for one operation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result    = '0;
        flags     = '0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shift_oor = (b >= SHIFT_LIMIT);

        case (op)
            OP_ADD: begin
                result           = sum[NB_DATA-1:0];
                flags[FLAG_CARRY] = sum[NB_DATA];
                flags[FLAG_OVF]   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow (A < B).
                result           = diff[NB_DATA-1:0];
                flags[FLAG_CARRY] = diff[NB_DATA];
                flags[FLAG_OVF]   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SRL: result = shift_oor ? '0 : (a >> b[NB_SHAMT-1:0]);
            OP_SRA: result = shift_oor ? {NB_DATA{a[MSB]}}
                                       : $unsigned($signed(a) >>> b[NB_SHAMT-1:0]);
            default: flags[FLAG_ILL] = 1'b1;
        endcase

        // Illegal opcodes report only the illegal flag with a zero result.
        if (!flags[FLAG_ILL]) begin
            flags[FLAG_NEG]  = result[MSB];
            flags[FLAG_ZERO] = (result == '0);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with sticky overflow flag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation_code,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow,
    output logic               o_carry,
    output logic               o_negative,
    output logic               o_zero,
    output logic               o_illegal,
    output logic               o_sticky_overflow,
    input  logic               i_clear_sticky
);

    logic               s1_valid;
    logic               s2_valid;
    logic               s1_en;
    logic               s2_en;
    logic [NB_DATA-1:0] s1_a;
    logic [NB_DATA-1:0] s1_b;
    logic [NB_OP-1:0]   s1_op;
    logic [NB_DATA-1:0] core_result;
    flags_t             core_flags;
    logic [NB_DATA-1:0] s2_result;
    flags_t             s2_flags;
    logic               sticky;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_en   = !s2_valid || i_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign o_ready = s1_en && !i_reset;

    // Stage 1 occupancy.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= i_valid;
        end
    end

    // Stage 1 operand capture on acceptance.
    always_ff @(posedge i_clk) begin
        // NOTE: payload registers are not reset; s1_valid alone qualifies them.
        if (i_valid && o_ready) begin
            s1_a  <= i_data_a;
            s1_b  <= i_data_b;
            s1_op <= i_operation_code;
        end
    end

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 2 result register; bubbles clear valid but leave the data untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= core_result;
                s2_flags  <= core_flags;
            end
        end
    end

    // Sticky overflow: a transferred overflow takes priority over a clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sticky <= 1'b0;
        end else if (o_valid && i_ready && s2_flags[FLAG_OVF]) begin
            sticky <= 1'b1;
        end else if (i_clear_sticky) begin
            sticky <= 1'b0;
        end
    end

    assign o_valid           = s2_valid;
    assign o_result          = s2_result;
    assign o_overflow        = s2_flags[FLAG_OVF];
    assign o_carry           = s2_flags[FLAG_CARRY];
    assign o_negative        = s2_flags[FLAG_NEG];
    assign o_zero            = s2_flags[FLAG_ZERO];
    assign o_illegal         = s2_flags[FLAG_ILL];
    assign o_sticky_overflow = sticky;

endmodule
